hc595_chain_scheduler: RTL
==========================

# hc595_chain_scheduler

Owns a daisy-chained 74HC595 shift-register chain and shares it among several frame requesters (bar-LED meter, status/indicator LED sources). Round-robin arbitrates whole frames, serialises the granted frame MSB-first on SER/SRCLK, and pulses RCLK to latch it. Sits between the LED-pattern generators and the board-level 595 pins. It replaces any per-source serialiser on those pins.

## Interface
- NREQ, 2: number of requesters (1..8)
- WIDTH, 24: frame length in bits = number of chained 595 outputs
- DIV, 2: SRCLK/RCLK half-period in i_clk cycles (>=1)
- REFRESH_CYCLES, 50000: idle cycles before the last frame is re-sent (only with refresh compiled in)

- i_clk  in  1  system clock, 50 MHz
- i_rst_n  in  1  asynchronous, active-low reset
- i_req_valid  in  NREQ  per-requester frame valid
- i_req_data  in  NREQ*WIDTH  frames; requester i uses bits [i*WIDTH +: WIDTH]
- o_req_ready  out  NREQ  one-hot accept strobe
- o_ser  out  1  serial data to first 595
- o_srclk  out  1  shift clock; 595 samples on rising edge
- o_rclk  out  1  latch clock; outputs update on rising edge
- o_busy  out  1  frame in progress
- o_grant_id  out  $clog2(NREQ) max 1  index of the last accepted requester

## Operation
- States: IDLE, SHIFT, LATCH.
- IDLE: o_req_ready[g] = 1 combinationally for g = first requester with valid at or after rr_ptr (wrapping). Transfer = valid & ready on a rising edge. The frame is captured into the shift buffer, o_grant_id <= g, rr_ptr <= (g+1) mod NREQ, next state SHIFT.
- Requesters hold valid and data stable until ready. Valid may drop without a transfer; no penalty.
- SHIFT: bit index b = WIDTH-1 down to 0. Each bit lasts 2*DIV cycles: DIV cycles with SRCLK=0 and SER=frame[b], then DIV cycles with SRCLK=1 and SER unchanged. After bit 0's high phase, go to LATCH.
- LATCH: SRCLK=0, SER=0, RCLK=1 for DIV cycles, then IDLE.
- o_busy = 1 in SHIFT and LATCH.
- The last transmitted frame is kept in a shadow register.
- Reset: o_ser=0, o_srclk=0, o_rclk=0, o_busy=0, o_req_ready=0, o_grant_id=0, rr_ptr=0, shadow=0, state IDLE.
- Reset asserted mid-frame aborts immediately. The 595 outputs keep their previous latched value because RCLK never rises.
- Counters: phase counter $clog2(DIV) max 1 bits; bit counter $clog2(WIDTH) bits. Wrap only by explicit compare, never by overflow.

## Timing
- o_ser, o_srclk and o_rclk are registered. The first SER bit appears the cycle after the accept edge.
- Frame occupancy from the accept edge: 2*DIV*WIDTH + DIV cycles. Default: 98 cycles.
- o_req_ready can re-assert on the first IDLE cycle after LATCH. There are no back-to-back IDLE bubbles beyond that one cycle.
- SER is stable ≥DIV cycles before and after each SRCLK rising edge. RCLK rises ≥DIV cycles after the final SRCLK rising edge.
- Simultaneous valids: round-robin order. With NREQ=2 and both valid continuously, grants alternate 0,1,0,1.
- NREQ=1: rr_ptr stays 0.

## Configuration
- HC595_SCHED_REFRESH_EN defined:
  - The idle counter counts consecutive IDLE cycles with no transfer, starting after the first completed frame.
  - At REFRESH_CYCLES it re-sends the shadow frame as an internal grant. o_req_ready stays 0 and o_grant_id and rr_ptr are unchanged.
  - A request valid on the expiry cycle wins; the refresh is dropped and the counter clears.
  - No refresh is sent before the first real frame.
- HC595_SCHED_REFRESH_EN undefined: no idle counter or refresh logic; the chain updates only on requests.

## Structure
- Package hc595_sched_pkg holds:
  - the state enum (IDLE/SHIFT/LATCH);
  - default parameter constants;
  - a helper function for the index-width clog2 with a minimum of 1.
- Sub-module hc595_rr_arbiter:
  - inputs: valid vector and rr_ptr;
  - outputs: one-hot grant and encoded index;
  - purely combinational.
- Pointer update and the serialiser FSM stay in the top level.

## Test plan
- Reset then single frame: requester 0 sends 24'hA5C3_0F; DIV=2. Sample SER on each SRCLK rise → bits 1010_0101_1100_0011_0000_1111 in that order. Exactly one RCLK pulse 2 cycles wide. o_busy high for 98 cycles.
- Contention: both valid from reset with frames 24'h000001 and 24'h800000 held continuously. Grants go 0,1,0,1; o_grant_id tracks them; no ready is issued while busy.
- Valid withdrawn: requester 1 raises valid while busy, then drops it before IDLE. No transfer occurs and the next grant goes to requester 0.
- Reset mid-frame: assert i_rst_n=0 at bit 10. All outputs go 0 immediately, no RCLK rise occurs, and a fresh frame is sent correctly after release.
- Refresh (macro defined, REFRESH_CYCLES=100): after one frame 24'h123456 and no requests, the identical frame is retransmitted 100 idle cycles later and o_req_ready stays 0. A valid raised on the expiry cycle is granted instead.
- DIV=1, WIDTH=8: frame 8'h81. SRCLK toggles every cycle, occupancy is 17 cycles, and the sampled bits are 1000_0001.

Source files
------------

// File: rtl/hc595_sched_pkg.sv
// Shared types and defaults for the 74HC595 chain scheduler and its round-robin arbiter.
package hc595_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    localparam int DEF_NREQ           = 2;
    localparam int DEF_WIDTH          = 24;
    localparam int DEF_DIV            = 2;
    localparam int DEF_REFRESH_CYCLES = 50000;

    // Width of a counter/index that must hold 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hc595_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module hc595_rr_arbiter
    import hc595_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]        valid,
    input  logic [idx_w(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]        grant,
    output logic [idx_w(NREQ)-1:0] idx,
    output logic                   found
);

    localparam int IW = idx_w(NREQ);

    function automatic int wrap(input int p, input int k);
        return (p + k >= NREQ) ? p + k - NREQ : p + k;
    endfunction

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && valid[wrap(int'(ptr), k)]) begin
                found                      = 1'b1;
                idx                        = IW'(wrap(int'(ptr), k));
                grant[wrap(int'(ptr), k)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hc595_chain_scheduler.sv
// Arbitrates whole frames onto a 74HC595 chain: MSB-first on SER/SRCLK, then an RCLK latch pulse.
// Optional idle refresh of the last frame is compiled in with HC595_SCHED_REFRESH_EN.
module hc595_chain_scheduler
    import hc595_sched_pkg::*;
#(
    parameter int NREQ           = DEF_NREQ,
    parameter int WIDTH          = DEF_WIDTH,
    parameter int DIV            = DEF_DIV,
    parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NREQ-1:0]         i_req_valid,
    input  logic [NREQ*WIDTH-1:0]   i_req_data,
    output logic [NREQ-1:0]         o_req_ready,
    output logic                    o_ser,
    output logic                    o_srclk,
    output logic                    o_rclk,
    output logic                    o_busy,
    output logic [idx_w(NREQ)-1:0]  o_grant_id
);

    localparam int IW = idx_w(NREQ);
    localparam int PW = idx_w(DIV);
    localparam int BW = idx_w(WIDTH);
    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
    localparam logic [BW-1:0] BIT_TOP = BW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [PW-1:0]    ph_q, ph_d;
    logic             ser_q, ser_d, srclk_q, srclk_d, rclk_q, rclk_d;
    logic [IW-1:0]    gid_q, gid_d, ptr_q, ptr_d;

    logic [NREQ-1:0]  arb_grant;
    logic [IW-1:0]    arb_idx;
    logic             arb_found;
    logic             accept;
    logic             refresh;
    logic [WIDTH-1:0] req_frame;

    hc595_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .valid (i_req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .found (arb_found)
    );

    assign accept    = (state_q == ST_IDLE) && arb_found;
    assign req_frame = i_req_data[int'(arb_idx)*WIDTH +: WIDTH];
    // Ready is gated by reset as well so nothing is offered while the block is held in reset.
    assign o_req_ready = (state_q == ST_IDLE && i_rst_n) ? arb_grant : '0;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_ser       = ser_q;
    assign o_srclk     = srclk_q;
    assign o_rclk      = rclk_q;
    assign o_grant_id  = gid_q;

    // The shadow doubles as the shift source: it is indexed, never shifted, so it always
    // holds the whole last frame for a refresh.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        bit_d    = bit_q;
        ph_d     = ph_q;
        ser_d    = ser_q;
        srclk_d  = srclk_q;
        rclk_d   = rclk_q;
        gid_d    = gid_q;
        ptr_d    = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shadow_d = req_frame;
                    gid_d    = arb_idx;
                    ptr_d    = (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
                end
                if (accept || refresh) begin
                    state_d = ST_SHIFT;
                    bit_d   = BIT_TOP;
                    ph_d    = '0;
                    srclk_d = 1'b0;
                    ser_d   = accept ? req_frame[WIDTH-1] : shadow_q[WIDTH-1];
                end
            end
            ST_SHIFT: begin
                if (ph_q != PH_LAST) begin
                    ph_d = ph_q + 1'b1;
                end else begin
                    ph_d = '0;
                    if (!srclk_q) begin
                        srclk_d = 1'b1;
                    end else if (bit_q == '0) begin
                        state_d = ST_LATCH;
                        srclk_d = 1'b0;
                        ser_d   = 1'b0;
                        rclk_d  = 1'b1;
                    end else begin
                        bit_d   = bit_q - 1'b1;
                        srclk_d = 1'b0;
                        ser_d   = shadow_q[bit_d];
                    end
                end
            end
            ST_LATCH: begin
                if (ph_q != PH_LAST) begin
                    ph_d = ph_q + 1'b1;
                end else begin
                    ph_d    = '0;
                    rclk_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: registers use <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            bit_q    <= '0;
            ph_q     <= '0;
            ser_q    <= 1'b0;
            srclk_q  <= 1'b0;
            rclk_q   <= 1'b0;
            gid_q    <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            bit_q    <= bit_d;
            ph_q     <= ph_d;
            ser_q    <= ser_d;
            srclk_q  <= srclk_d;
            rclk_q   <= rclk_d;
            gid_q    <= gid_d;
            ptr_q    <= ptr_d;
        end
    end

`ifdef HC595_SCHED_REFRESH_EN
    localparam int CW = idx_w(REFRESH_CYCLES);

    logic [CW-1:0] idle_q, idle_d;
    logic          have_q, have_d;

    // Expiry is the REFRESH_CYCLES-th idle cycle; a real request on that cycle wins.
    assign refresh = (state_q == ST_IDLE) && !arb_found && have_q
                     && (idle_q == CW'(REFRESH_CYCLES - 1));

    always_comb begin
        idle_d = '0;
        have_d = have_q;
        if (state_q == ST_LATCH && state_d == ST_IDLE)
            have_d = 1'b1;
        if (state_q == ST_IDLE && have_q && !accept && !refresh)
            idle_d = idle_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idle_q <= '0;
            have_q <= 1'b0;
        end else begin
            idle_q <= idle_d;
            have_q <= have_d;
        end
    end
`else
    logic unused_refresh_cfg;
    assign refresh            = 1'b0;
    assign unused_refresh_cfg = ^REFRESH_CYCLES;
`endif

endmodule
